// File: rtl/pma_region_table_if.sv
// Register-port and lookup-port bundle for pma_region_table.
// Signal names keep the block's _i/_o port naming as seen from the table itself.
interface pma_region_table_if #(
    parameter int unsigned NrRules   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned CfgAddrWidth = $clog2(NrRules) + 2;
    localparam int unsigned RuleIdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic                    cfg_req_i;
    logic                    cfg_we_i;
    logic [CfgAddrWidth-1:0] cfg_addr_i;
    logic [DataWidth-1:0]    cfg_wdata_i;
    logic                    cfg_rvalid_o;
    logic [DataWidth-1:0]    cfg_rdata_o;
    logic                    cfg_err_o;
    logic                    lookup_valid_i;
    logic [AddrWidth-1:0]    lookup_addr_i;
    logic                    lookup_valid_o;
    logic [2:0]              lookup_attr_o;
    logic                    lookup_hit_o;
    logic [RuleIdxWidth-1:0] lookup_rule_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lookup_valid_i, lookup_addr_i,
        input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        input  lookup_valid_o, lookup_attr_o, lookup_hit_o, lookup_rule_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lookup_valid_i, lookup_addr_i,
        output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        output lookup_valid_o, lookup_attr_o, lookup_hit_o, lookup_rule_o
    );
endinterface

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table: NrRules base/length/cfg rules, 1-cycle lookup.
// Define PMA_REGION_HIT_CNT_EN to add a 32-bit saturating hit counter per rule (word 3).
module pma_region_table #(
    parameter int unsigned                          NrRules     = 4,
    parameter int unsigned                          AddrWidth   = 64,
    parameter int unsigned                          DataWidth   = 64,
    parameter logic [2:0]                           DefaultAttr = 3'b000,
    parameter logic [NrRules-1:0][AddrWidth-1:0]    RstBase     = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0]    RstLength   = '0,
    parameter logic [NrRules-1:0][7:0]              RstCfg      = '0
) (
    input logic               clk_i,
    input logic               rst_i,
    pma_region_table_if.slave bus
);
    localparam int unsigned CfgAddrWidth = $clog2(NrRules) + 2;
    localparam int unsigned RuleIdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;
    // cfg byte: bit0 cached, bit1 exec, bit2 nonidem, bit3 enable, bit7 lock
    localparam logic [7:0]  CfgMask      = 8'h8F;

    logic [NrRules-1:0][AddrWidth-1:0] base_q, base_d;
    logic [NrRules-1:0][AddrWidth-1:0] length_q, length_d;
    logic [NrRules-1:0][7:0]           cfg_q, cfg_d;

    logic                    cfg_rvalid_q, cfg_rvalid_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [DataWidth-1:0]    cfg_rdata_q, cfg_rdata_d;
    logic                    lookup_valid_q, lookup_valid_d;
    logic                    lookup_hit_q, lookup_hit_d;
    logic [2:0]              lookup_attr_q, lookup_attr_d;
    logic [RuleIdxWidth-1:0] lookup_rule_q, lookup_rule_d;

    logic [CfgAddrWidth-1:0] cfg_rule_s;
    logic [1:0]              cfg_word_s;
    logic [RuleIdxWidth-1:0] cfg_idx_s;
    logic                    cfg_rule_ok_s;
    logic                    cfg_locked_s;
    logic [NrRules-1:0]      match_s;
    logic                    win_hit_s;
    logic [RuleIdxWidth-1:0] win_idx_s;
    logic [2:0]              win_attr_s;
    logic                    unused_wdata_s;

`ifdef PMA_REGION_HIT_CNT_EN
    localparam logic [31:0]   CntMax = 32'hFFFF_FFFF;
    logic [NrRules-1:0][31:0] hit_cnt_q, hit_cnt_d;
    logic [NrRules-1:0]       cnt_clr_s;
`endif

    assign unused_wdata_s = ^bus.cfg_wdata_i;

    // Split the config word address into rule index and word select; out-of-range rules never lock.
    always_comb begin
        cfg_rule_s    = bus.cfg_addr_i >> 2;
        cfg_word_s    = bus.cfg_addr_i[1:0];
        cfg_idx_s     = RuleIdxWidth'(cfg_rule_s);
        cfg_rule_ok_s = (cfg_rule_s < CfgAddrWidth'(NrRules));
        cfg_locked_s  = cfg_rule_ok_s ? cfg_q[cfg_idx_s][7] : 1'b0;
    end

    // Config port: write decode with lock/range checks, read mux, one-cycle response.
    always_comb begin
        base_d       = base_q;
        length_d     = length_q;
        cfg_d        = cfg_q;
        cfg_rvalid_d = bus.cfg_req_i;
        cfg_err_d    = 1'b0;
        cfg_rdata_d  = '0;
`ifdef PMA_REGION_HIT_CNT_EN
        cnt_clr_s    = '0;
`endif
        if (!bus.cfg_req_i) begin
            cfg_err_d = 1'b0;
        end else if (!cfg_rule_ok_s) begin
            cfg_err_d = 1'b1;
        end else if (bus.cfg_we_i) begin
            case (cfg_word_s)
                2'd0: begin
                    if (cfg_locked_s) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        base_d[cfg_idx_s] = bus.cfg_wdata_i[AddrWidth-1:0];
                    end
                end
                2'd1: begin
                    if (cfg_locked_s) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        length_d[cfg_idx_s] = bus.cfg_wdata_i[AddrWidth-1:0];
                    end
                end
                2'd2: begin
                    if (cfg_locked_s) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_d[cfg_idx_s] = bus.cfg_wdata_i[7:0] & CfgMask;
                    end
                end
                2'd3: begin
`ifdef PMA_REGION_HIT_CNT_EN
                    // Counter clear bypasses the lock so software can always re-arm statistics.
                    cnt_clr_s[cfg_idx_s] = 1'b1;
`else
                    cfg_err_d = 1'b1;
`endif
                end
                default: cfg_err_d = 1'b1;
            endcase
        end else begin
            case (cfg_word_s)
                2'd0:    cfg_rdata_d = DataWidth'(base_q[cfg_idx_s]);
                2'd1:    cfg_rdata_d = DataWidth'(length_q[cfg_idx_s]);
                2'd2:    cfg_rdata_d = DataWidth'(cfg_q[cfg_idx_s]);
`ifdef PMA_REGION_HIT_CNT_EN
                2'd3:    cfg_rdata_d = DataWidth'(hit_cnt_q[cfg_idx_s]);
`else
                2'd3:    cfg_rdata_d = '0;
`endif
                default: cfg_rdata_d = '0;
            endcase
        end
    end

    // Region match per rule and lowest-index priority select; the end of a region never wraps.
    always_comb begin
        match_s    = '0;
        win_hit_s  = 1'b0;
        win_idx_s  = '0;
        win_attr_s = DefaultAttr;
        for (int i = 0; i < NrRules; i++) begin
            match_s[i] = cfg_q[i][3] && (length_q[i] != '0) &&
                         (bus.lookup_addr_i >= base_q[i]) &&
                         ((bus.lookup_addr_i - base_q[i]) < length_q[i]);
        end
        for (int i = NrRules - 1; i >= 0; i--) begin
            win_hit_s  = match_s[i] ? 1'b1 : win_hit_s;
            win_idx_s  = match_s[i] ? RuleIdxWidth'(i) : win_idx_s;
            win_attr_s = match_s[i] ? cfg_q[i][2:0] : win_attr_s;
        end
    end

    // Lookup result stage; all result fields are forced to zero when no lookup was issued.
    always_comb begin
        lookup_valid_d = bus.lookup_valid_i;
        lookup_hit_d   = bus.lookup_valid_i & win_hit_s;
        lookup_rule_d  = bus.lookup_valid_i ? win_idx_s : '0;
        lookup_attr_d  = bus.lookup_valid_i ? win_attr_s : 3'b000;
    end

`ifdef PMA_REGION_HIT_CNT_EN
    // Saturating hit counters; a clear in the same cycle as an increment wins.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        for (int i = 0; i < NrRules; i++) begin
            if (cnt_clr_s[i]) begin
                hit_cnt_d[i] = 32'd0;
            end else if (bus.lookup_valid_i && win_hit_s &&
                         (win_idx_s == RuleIdxWidth'(i)) && (hit_cnt_q[i] != CntMax)) begin
                hit_cnt_d[i] = hit_cnt_q[i] + 32'd1;
            end else begin
                hit_cnt_d[i] = hit_cnt_q[i];
            end
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end
`endif

    // Rule storage and output registers; reset drops any in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q   <= RstBase;
            length_q <= RstLength;
            for (int i = 0; i < NrRules; i++) begin
                cfg_q[i] <= RstCfg[i] & CfgMask;
            end
            cfg_rvalid_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            cfg_rdata_q    <= '0;
            lookup_valid_q <= 1'b0;
            lookup_hit_q   <= 1'b0;
            lookup_attr_q  <= 3'b000;
            lookup_rule_q  <= '0;
        end else begin
            base_q         <= base_d;
            length_q       <= length_d;
            cfg_q          <= cfg_d;
            cfg_rvalid_q   <= cfg_rvalid_d;
            cfg_err_q      <= cfg_err_d;
            cfg_rdata_q    <= cfg_rdata_d;
            lookup_valid_q <= lookup_valid_d;
            lookup_hit_q   <= lookup_hit_d;
            lookup_attr_q  <= lookup_attr_d;
            lookup_rule_q  <= lookup_rule_d;
        end
    end

    assign bus.cfg_rvalid_o   = cfg_rvalid_q;
    assign bus.cfg_err_o      = cfg_err_q;
    assign bus.cfg_rdata_o    = cfg_rdata_q;
    assign bus.lookup_valid_o = lookup_valid_q;
    assign bus.lookup_hit_o   = lookup_hit_q;
    assign bus.lookup_attr_o  = lookup_attr_q;
    assign bus.lookup_rule_o  = lookup_rule_q;
endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table with three rules so that rule index NrRules is addressable.
module tb_pma_region_table;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam logic [2:0]  DEF_ATTR = 3'b010;
    localparam logic [NR-1:0][AW-1:0] RST_BASE = {64'h0, 64'h0, 64'h8000_0000};
    localparam logic [NR-1:0][AW-1:0] RST_LEN  = {64'h0, 64'h0, 64'h4000_0000};
    localparam logic [NR-1:0][7:0]    RST_CFG  = {8'h00, 8'h00, 8'h0B};

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pma_region_table_if #(.NrRules(NR), .AddrWidth(AW), .DataWidth(DW)) bus ();

    pma_region_table #(
        .NrRules(NR), .AddrWidth(AW), .DataWidth(DW), .DefaultAttr(DEF_ATTR),
        .RstBase(RST_BASE), .RstLength(RST_LEN), .RstCfg(RST_CFG)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cfg_write(input int rule, input int word, input logic [63:0] data,
                             output logic rv, output logic err);
        @(negedge clk);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 4'(rule * 4 + word);
        bus.cfg_wdata_i = data;
        @(negedge clk);
        bus.cfg_req_i = 1'b0;
        bus.cfg_we_i  = 1'b0;
        rv  = bus.cfg_rvalid_o;
        err = bus.cfg_err_o;
    endtask

    task automatic cfg_read(input int rule, input int word,
                            output logic rv, output logic err, output logic [63:0] data);
        @(negedge clk);
        bus.cfg_req_i  = 1'b1;
        bus.cfg_we_i   = 1'b0;
        bus.cfg_addr_i = 4'(rule * 4 + word);
        @(negedge clk);
        bus.cfg_req_i = 1'b0;
        rv   = bus.cfg_rvalid_o;
        err  = bus.cfg_err_o;
        data = bus.cfg_rdata_o;
    endtask

    // Result packed as {valid, hit, rule[1:0], attr[2:0]}.
    task automatic do_lookup(input logic [63:0] a, output logic [6:0] res);
        @(negedge clk);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_addr_i  = a;
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        res = {bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o};
    endtask

    task automatic test_reset();
        logic [6:0]  res;
        logic        rv, err;
        logic [63:0] d;
        rst = 1'b1;
        bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b0; bus.cfg_addr_i = 4'd2; bus.cfg_wdata_i = 64'h0;
        bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = 64'h8000_1000;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o,
             bus.cfg_rvalid_o, bus.cfg_err_o} !== 9'b0 || bus.cfg_rdata_o !== 64'h0) begin
            bad++; $display("FAIL reset_outputs: got lv=%b rv=%b rd=%h want all 0",
                            bus.lookup_valid_o, bus.cfg_rvalid_o, bus.cfg_rdata_o);
        end
        rst = 1'b0; bus.cfg_req_i = 1'b0; bus.lookup_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.lookup_valid_o, bus.cfg_rvalid_o} !== 2'b00) begin
            bad++; $display("FAIL reset_drop: got lv=%b rv=%b want 0 0", bus.lookup_valid_o, bus.cfg_rvalid_o);
        end
        do_lookup(64'h8000_1000, res);
        total++;
        if (res !== 7'b1_1_00_011) begin bad++; $display("FAIL reset_lookup: got %b want 1100011", res); end
        @(negedge clk);
        total++;
        if ({bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o} !== 7'b0) begin
            bad++; $display("FAIL idle_zero: got %b want 0000000",
                            {bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o});
        end
        cfg_read(0, 2, rv, err, d);
        total++;
        if ({rv, err, d} !== {1'b1, 1'b0, 64'h0B}) begin
            bad++; $display("FAIL reset_cfg: got rv=%b err=%b d=%h want 1 0 0b", rv, err, d);
        end
        cfg_read(0, 0, rv, err, d);
        total++;
        if (d !== 64'h8000_0000) begin bad++; $display("FAIL reset_base: got %h want 80000000", d); end
        @(negedge clk);
        total++;
        if (bus.cfg_rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_pulse: got %b want 0", bus.cfg_rvalid_o); end
    endtask

    task automatic test_priority();
        logic [6:0] res;
        logic       rv, err;
        logic [5:0] errs;
        cfg_write(1, 0, 64'h1_0000, rv, errs[0]);
        cfg_write(1, 1, 64'h1_0000, rv, errs[1]);
        cfg_write(1, 2, 64'h0C, rv, errs[2]);
        cfg_write(2, 0, 64'h0, rv, errs[3]);
        cfg_write(2, 1, 64'h10_0000, rv, errs[4]);
        cfg_write(2, 2, 64'h09, rv, errs[5]);
        total++;
        if ({rv, errs} !== 7'b1_000000) begin bad++; $display("FAIL prio_writes: got rv=%b errs=%b want 1 000000", rv, errs); end
        do_lookup(64'h1_8000, res);
        total++;
        if (res !== 7'b1_1_01_100) begin bad++; $display("FAIL prio_rule1: got %b want 1101100", res); end
        do_lookup(64'h2_0000, res);
        total++;
        if (res !== 7'b1_1_10_001) begin bad++; $display("FAIL prio_rule2: got %b want 1110001", res); end
        do_lookup(64'h10_0000, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL prio_miss: got %b want 1000010", res); end
        err = 1'b0;
    endtask

    task automatic test_cfg_mask();
        logic        rv, err;
        logic [63:0] d;
        cfg_write(1, 2, 64'hFFFF_FFFF_FFFF_FF7F, rv, err);
        cfg_read(1, 2, rv, err, d);
        total++;
        if ({err, d} !== {1'b0, 64'h0F}) begin bad++; $display("FAIL cfg_mask: got err=%b d=%h want 0 0f", err, d); end
        cfg_read(1, 1, rv, err, d);
        total++;
        if (d !== 64'h1_0000) begin bad++; $display("FAIL length_read: got %h want 10000", d); end
    endtask

    task automatic test_boundaries();
        logic [6:0] res;
        logic       rv, err;
        cfg_write(2, 0, 64'h1000, rv, err);
        cfg_write(2, 1, 64'h1000, rv, err);
        cfg_write(2, 2, 64'h08, rv, err);
        do_lookup(64'h0FFF, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL bnd_below: got %b want 1000010", res); end
        do_lookup(64'h1000, res);
        total++;
        if (res !== 7'b1_1_10_000) begin bad++; $display("FAIL bnd_base: got %b want 1110000", res); end
        do_lookup(64'h1FFF, res);
        total++;
        if (res !== 7'b1_1_10_000) begin bad++; $display("FAIL bnd_last: got %b want 1110000", res); end
        do_lookup(64'h2000, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL bnd_end: got %b want 1000010", res); end
        cfg_write(2, 1, 64'h0, rv, err);
        do_lookup(64'h1000, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL bnd_len0: got %b want 1000010", res); end
        cfg_write(2, 1, 64'h1000, rv, err);
        cfg_write(2, 2, 64'h07, rv, err);
        do_lookup(64'h1000, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL bnd_disabled: got %b want 1000010", res); end
        cfg_write(2, 2, 64'h08, rv, err);
    endtask

    task automatic test_wrap();
        logic [6:0] res;
        logic       rv, err;
        cfg_write(1, 0, 64'hFFFF_FFFF_FFFF_F000, rv, err);
        cfg_write(1, 1, 64'h2000, rv, err);
        cfg_write(1, 2, 64'h09, rv, err);
        do_lookup(64'hFFFF_FFFF_FFFF_FFFF, res);
        total++;
        if (res !== 7'b1_1_01_001) begin bad++; $display("FAIL wrap_top: got %b want 1101001", res); end
        do_lookup(64'h0, res);
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL wrap_zero: got %b want 1000010", res); end
    endtask

    task automatic test_lock();
        logic [6:0]  res;
        logic        rv, err;
        logic [63:0] d;
        cfg_write(0, 2, 64'h8B, rv, err);
        total++;
        if ({rv, err} !== 2'b10) begin bad++; $display("FAIL lock_set: got rv=%b err=%b want 1 0", rv, err); end
        cfg_write(0, 0, 64'h0, rv, err);
        total++;
        if ({rv, err} !== 2'b11) begin bad++; $display("FAIL lock_err: got rv=%b err=%b want 1 1", rv, err); end
        cfg_read(0, 0, rv, err, d);
        total++;
        if ({err, d} !== {1'b0, 64'h8000_0000}) begin bad++; $display("FAIL lock_base: got err=%b d=%h want 0 80000000", err, d); end
        cfg_write(0, 2, 64'h00, rv, err);
        cfg_read(0, 2, rv, err, d);
        total++;
        if (d !== 64'h8B) begin bad++; $display("FAIL lock_cfg: got %h want 8b", d); end
        do_lookup(64'h8000_1000, res);
        total++;
        if (res !== 7'b1_1_00_011) begin bad++; $display("FAIL lock_lookup: got %b want 1100011", res); end
    endtask

    task automatic test_out_of_range();
        logic        rv, err;
        logic [63:0] d;
        cfg_read(3, 0, rv, err, d);
        total++;
        if ({rv, err, d} !== {1'b1, 1'b1, 64'h0}) begin bad++; $display("FAIL oor_read: got rv=%b err=%b d=%h want 1 1 0", rv, err, d); end
        cfg_write(3, 1, 64'h55, rv, err);
        total++;
        if ({rv, err} !== 2'b11) begin bad++; $display("FAIL oor_write: got rv=%b err=%b want 1 1", rv, err); end
    endtask

    task automatic test_same_cycle();
        logic [6:0] res;
        @(negedge clk);
        bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 4'(2 * 4 + 0); bus.cfg_wdata_i = 64'h3000;
        bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = 64'h1000;
        @(negedge clk);
        bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0;
        res = {bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o};
        total++;
        if ({res, bus.cfg_rvalid_o, bus.cfg_err_o} !== 9'b1_1_10_000_1_0) begin
            bad++; $display("FAIL same_cycle_old: got %b rv=%b err=%b want 1110000 1 0", res, bus.cfg_rvalid_o, bus.cfg_err_o);
        end
        @(negedge clk);
        bus.lookup_valid_i = 1'b0;
        res = {bus.lookup_valid_o, bus.lookup_hit_o, bus.lookup_rule_o, bus.lookup_attr_o};
        total++;
        if (res !== {4'b1_0_00, DEF_ATTR}) begin bad++; $display("FAIL same_cycle_new: got %b want 1000010", res); end
    endtask

    task automatic test_word3();
        logic        rv, err;
        logic [63:0] d;
`ifdef PMA_REGION_HIT_CNT_EN
        logic [6:0]  res;
        cfg_write(0, 3, 64'h0, rv, err);
        total++;
        if ({rv, err} !== 2'b10) begin bad++; $display("FAIL cnt_clr_locked: got rv=%b err=%b want 1 0", rv, err); end
        for (int k = 0; k < 5; k++) do_lookup(64'h8000_1000, res);
        cfg_read(0, 3, rv, err, d);
        total++;
        if ({err, d} !== {1'b0, 64'd5}) begin bad++; $display("FAIL cnt_five: got err=%b d=%h want 0 5", err, d); end
        cfg_write(0, 3, 64'h0, rv, err);
        cfg_read(0, 3, rv, err, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL cnt_clear: got %h want 0", d); end
        force dut.hit_cnt_q = {NR{32'hFFFF_FFFF}};
        @(negedge clk);
        release dut.hit_cnt_q;
        do_lookup(64'h8000_1000, res);
        cfg_read(0, 3, rv, err, d);
        total++;
        if (d !== 64'hFFFF_FFFF) begin bad++; $display("FAIL cnt_saturate: got %h want ffffffff", d); end
        @(negedge clk);
        bus.cfg_req_i = 1'b1; bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 4'd3; bus.cfg_wdata_i = 64'h0;
        bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = 64'h8000_1000;
        @(negedge clk);
        bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.lookup_valid_i = 1'b0;
        cfg_read(0, 3, rv, err, d);
        total++;
        if (d !== 64'h0) begin bad++; $display("FAIL cnt_clr_vs_inc: got %h want 0", d); end
`else
        cfg_read(0, 3, rv, err, d);
        total++;
        if ({rv, err, d} !== {1'b1, 1'b0, 64'h0}) begin bad++; $display("FAIL word3_read: got rv=%b err=%b d=%h want 1 0 0", rv, err, d); end
        cfg_write(1, 3, 64'h0, rv, err);
        total++;
        if ({rv, err} !== 2'b11) begin bad++; $display("FAIL word3_write: got rv=%b err=%b want 1 1", rv, err); end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_priority();
        test_cfg_mask();
        test_boundaries();
        test_wrap();
        test_lock();
        test_out_of_range();
        test_same_cycle();
        test_word3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
